// File: rtl/sha256_word_receiver.sv
// sha256_word_receiver
//
// Receiving end of the 32-bit SHA-256 message word stream. Words strobed by
// EN are collected into a 16-entry message-schedule buffer. Once a full
// 512-bit block is present it is offered to the compression core with a
// valid/ready handshake. The buffer stays frozen from then until the core
// reports completion, and busy tells the feeder to hold off.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous reset, active-low
//   init       start of a new message: clears word/block counters and ovr
//   EN         word strobe; idata32 valid this cycle
//   idata32    message word (first strobed word is W0)
//   busy       receiver cannot accept words (block full or core running)
//   blk_valid  16 words buffered and offered to the core
//   blk_ready  core accepts the block (handshake on blk_valid & blk_ready)
//   first_blk  offered block is block 0 of the message
//   core_done  one-cycle pulse, core finished the block
//   w_rd_idx   word index the core is reading
//   w_rd_data  registered buffer word at w_rd_idx (1-cycle latency)
//   blk_cnt    blocks completed since last init, wraps 255 -> 0
//   ovr        sticky: EN seen while busy

module sha256_word_receiver #(
   parameter int NWORDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        EN,
   input  logic [31:0] idata32,
   output logic        busy,
   output logic        blk_valid,
   input  logic        blk_ready,
   output logic        first_blk,
   input  logic        core_done,
   input  logic [3:0]  w_rd_idx,
   output logic [31:0] w_rd_data,
   output logic [7:0]  blk_cnt,
   output logic        ovr
);

   localparam int WC_W = $clog2(NWORDS);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(NWORDS - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FULL    = 2'd1,
      RUN     = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [WC_W-1:0] wc;
   logic [31:0]     msg_buf [NWORDS];
   logic            wr_en;
   logic            blk_done;

   // A word is only taken while collecting; init discards a coincident word.
   assign wr_en    = rst && EN && (state == COLLECT) && !init;
   assign blk_done = (state == RUN) && core_done;

   // Next-state logic; init overrides every other transition.
   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (EN && (wc == WC_LAST)) state_nxt = FULL;
         FULL:    if (blk_ready)             state_nxt = RUN;
         RUN:     if (core_done)             state_nxt = COLLECT;
         default:                            state_nxt = COLLECT;
      endcase
      if (init) state_nxt = COLLECT;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= COLLECT;
         wc        <= '0;
         blk_cnt   <= '0;
         ovr       <= 1'b0;
         w_rd_data <= '0;
      end else begin
         state     <= state_nxt;
         w_rd_data <= msg_buf[w_rd_idx];
         if (init) begin
            wc      <= '0;
            blk_cnt <= '0;
            ovr     <= 1'b0;
         end else begin
            // wc wraps to 0 on the 16th word, ready for the next block.
            if (wr_en)
               wc <= wc + 1'b1;
            if (blk_done)
               blk_cnt <= blk_cnt + 8'd1;
            if (EN && (state != COLLECT))
               ovr <= 1'b1;
         end
      end
   end

   // Buffer storage carries no reset; stale contents are simply overwritten.
   always_ff @(posedge clk) begin
      if (wr_en)
         msg_buf[wc] <= idata32;
   end

   assign busy      = (state != COLLECT);
   assign blk_valid = (state == FULL);
   assign first_blk = (blk_cnt == 8'd0);

endmodule

// File: tb/tb_sha256_word_receiver.sv
// Testbench for sha256_word_receiver: directed test-plan sequences followed
// by randomized traffic, all checked against a block-level reference model.

module tb_sha256_word_receiver;

   logic        clk = 1'b0;
   logic        rst;
   logic        init;
   logic        en;
   logic [31:0] idata32;
   logic        busy;
   logic        blk_valid;
   logic        blk_ready;
   logic        first_blk;
   logic        core_done;
   logic [3:0]  w_rd_idx;
   logic [31:0] w_rd_data;
   logic [7:0]  blk_cnt;
   logic        ovr;

   sha256_word_receiver #(.NWORDS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .init      (init),
      .EN        (en),
      .idata32   (idata32),
      .busy      (busy),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .first_blk (first_blk),
      .core_done (core_done),
      .w_rd_idx  (w_rd_idx),
      .w_rd_data (w_rd_data),
      .blk_cnt   (blk_cnt),
      .ovr       (ovr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: number of words held, whether the core has taken the
   // block, blocks finished, overrun flag and the buffer image.
   int          m_nwords = 0;
   bit          m_taken  = 0;
   int          m_blocks = 0;
   bit          m_ovr    = 0;
   logic [31:0] m_mem   [16];
   bit          m_known [16];
   logic [31:0] m_rd     = 0;
   bit          m_rd_ok  = 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: apply model rules to the inputs present at the edge, then
   // compare every output shortly after the edge.
   task automatic tick();
      bit full;
      @(posedge clk);
      if (!rst) begin
         m_nwords = 0; m_taken = 0; m_blocks = 0; m_ovr = 0;
         m_rd = 0; m_rd_ok = 1;
      end else begin
         m_rd    = m_mem[w_rd_idx];
         m_rd_ok = m_known[w_rd_idx];
         if (init) begin
            m_nwords = 0; m_taken = 0; m_blocks = 0; m_ovr = 0;
         end else begin
            full = (m_nwords == 16);
            if (en) begin
               if (full) m_ovr = 1;
               else begin
                  m_mem[m_nwords]   = idata32;
                  m_known[m_nwords] = 1;
                  m_nwords++;
               end
            end
            if (full && !m_taken && blk_ready) m_taken = 1;
            else if (full && m_taken && core_done) begin
               m_nwords = 0;
               m_taken  = 0;
               m_blocks = (m_blocks + 1) % 256;
            end
         end
      end
      #1;
      chk("busy",      busy,      32'(m_nwords == 16));
      chk("blk_valid", blk_valid, 32'(m_nwords == 16 && !m_taken));
      chk("first_blk", first_blk, 32'(m_blocks == 0));
      chk("blk_cnt",   blk_cnt,   32'(m_blocks));
      chk("ovr",       ovr,       32'(m_ovr));
      if (m_rd_ok) chk("w_rd_data", w_rd_data, m_rd);
   endtask

   task automatic idle();
      init = 0; en = 0; blk_ready = 0; core_done = 0;
   endtask

   task automatic send_block(input logic [31:0] base);
      for (int k = 0; k < 16; k++) begin
         en = 1; idata32 = base + 32'(k);
         tick();
      end
      en = 0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_mem[i] = '0;
         m_known[i] = 0;
      end
      rst = 0; idata32 = 0; w_rd_idx = 0;
      idle();
      tick();
      tick();
      chk("reset_rd", w_rd_data, 32'h0);
      chk("reset_first", first_blk, 32'h1);
      rst = 1;

      // Full block
      init = 1; tick(); init = 0;
      w_rd_idx = 5;
      send_block(32'h0100_0000);
      chk("full_busy", busy, 32'h1);
      chk("full_valid", blk_valid, 32'h1);
      chk("full_first", first_blk, 32'h1);
      tick();
      chk("rd_idx5", w_rd_data, 32'h0100_0005);

      // Handshake held off, then accepted
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_valid", blk_valid, 32'h1);
      end
      blk_ready = 1; tick(); blk_ready = 0;
      chk("run_valid", blk_valid, 32'h0);
      chk("run_busy", busy, 32'h1);

      // Overrun during RUN
      w_rd_idx = 0;
      en = 1; idata32 = 32'hDEAD_BEEF; tick(); en = 0;
      chk("ovr_set", ovr, 32'h1);
      tick();
      chk("ovr_w0", w_rd_data, 32'h0100_0000);

      core_done = 1; tick(); core_done = 0;
      chk("done_busy", busy, 32'h0);
      chk("done_cnt", blk_cnt, 32'd1);
      send_block(32'h0200_0000);
      chk("blk2_first", first_blk, 32'h0);
      blk_ready = 1; tick(); blk_ready = 0;
      core_done = 1; tick(); core_done = 0;
      init = 1; tick(); init = 0;
      chk("init_ovr", ovr, 32'h0);
      chk("init_cnt", blk_cnt, 32'h0);

      // Init priority over a coincident word
      for (int k = 0; k < 7; k++) begin
         en = 1; idata32 = 32'h0700_0000 + 32'(k); tick();
      end
      init = 1; en = 1; idata32 = 32'hBAD0_0000; tick(); init = 0;
      for (int k = 0; k < 16; k++) begin
         en = 1; idata32 = 32'h0300_0000 + 32'(k); tick();
         if (k == 14) chk("prio_not_full", blk_valid, 32'h0);
      end
      en = 0;
      chk("prio_full", blk_valid, 32'h1);
      w_rd_idx = 0; tick();
      chk("prio_w0", w_rd_data, 32'h0300_0000);

      // Reset while FULL
      rst = 0; tick(); rst = 1;
      chk("rst_valid", blk_valid, 32'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_cnt", blk_cnt, 32'h0);

      // 256 blocks without init: counter wraps
      for (int b = 0; b < 256; b++) begin
         w_rd_idx = 4'($urandom_range(0, 15));
         send_block($urandom);
         blk_ready = 1; tick(); blk_ready = 0;
         core_done = 1; tick(); core_done = 0;
         if (b == 254) chk("cnt_255", blk_cnt, 32'd255);
      end
      chk("wrap_cnt", blk_cnt, 32'h0);
      chk("wrap_first", first_blk, 32'h1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 399) != 0);
         init      = ($urandom_range(0, 149) == 0);
         en        = ($urandom_range(0, 3) != 0);
         idata32   = $urandom;
         blk_ready = ($urandom_range(0, 3) == 0);
         core_done = ($urandom_range(0, 5) == 0);
         w_rd_idx  = 4'($urandom_range(0, 15));
         tick();
      end
      rst = 1;
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
